// File: rtl/oitf_track_if.sv
// Bundle between the dispatch/writeback stages and the outstanding-write
// tracker (oitf_track).
//   master : the pipeline side. It drives dispatch, retire and flush requests
//            and watches the hazard and status outputs.
//   slave  : the tracker itself.
// Signal groups:
//   dispatch : dis_ena, dis_ready, dis_rdwen, dis_rdidx, dis_rs1en/idx,
//              dis_rs2en/idx
//   retire   : ret_ena, ret_rdidx, ret_rdwen, ret_err
//   control  : flush
//   status   : match_rs1, match_rs2, match_rd, empty, full, count
interface oitf_track_if #(
  parameter int PTR_W = 2,
  parameter int IDX_W = 5
);
  logic             dis_ena;
  logic             dis_ready;
  logic             dis_rdwen;
  logic [IDX_W-1:0] dis_rdidx;
  logic             dis_rs1en;
  logic             dis_rs2en;
  logic [IDX_W-1:0] dis_rs1idx;
  logic [IDX_W-1:0] dis_rs2idx;
  logic             ret_ena;
  logic [IDX_W-1:0] ret_rdidx;
  logic             ret_rdwen;
  logic             flush;
  logic             match_rs1;
  logic             match_rs2;
  logic             match_rd;
  logic             empty;
  logic             full;
  logic [PTR_W:0]   count;
  logic             ret_err;

  modport master (
    output dis_ena, dis_rdwen, dis_rdidx, dis_rs1en, dis_rs2en,
           dis_rs1idx, dis_rs2idx, ret_ena, flush,
    input  dis_ready, ret_rdidx, ret_rdwen, match_rs1, match_rs2,
           match_rd, empty, full, count, ret_err
  );

  modport slave (
    input  dis_ena, dis_rdwen, dis_rdidx, dis_rs1en, dis_rs2en,
           dis_rs1idx, dis_rs2idx, ret_ena, flush,
    output dis_ready, ret_rdidx, ret_rdwen, match_rs1, match_rs2,
           match_rd, empty, full, count, ret_err
  );
endinterface

// File: rtl/oitf_track.sv
// Outstanding-instruction tracking FIFO. Each dispatched instruction takes
// one entry, and the entry stays until writeback retires it in order. Source
// and destination indices of the instruction being dispatched are compared
// against every live entry. The results are RAW (rs1/rs2) and WAW (rd)
// hazard flags.
// Ports:
//   clk   : clock; all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : oitf_track_if.slave. It carries dispatch, retire, flush, hazard
//           and status signals.
// DEPTH must be a power of two (2..16), and PTR_W must equal log2(DEPTH).
module oitf_track #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int IDX_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  oitf_track_if.slave bus
);

  localparam logic [PTR_W:0] ONE = {{PTR_W{1'b0}}, 1'b1};

  // Each pointer carries one extra MSB. That MSB is a wrap bit, and it
  // separates the full case from the empty case.
  logic [PTR_W:0]   alc_ptr_reg;
  logic [PTR_W:0]   ret_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             ret_err_reg;
  logic [DEPTH-1:0] vld_reg;

  // Payload storage has no reset. Every reader is qualified by vld or
  // by empty.
  logic [DEPTH-1:0] rdwen_reg;
  logic [IDX_W-1:0] rdidx_reg [DEPTH];

  logic [PTR_W-1:0] alc_idx;
  logic [PTR_W-1:0] ret_idx;
  logic             empty;
  logic             full;
  logic             alloc;
  logic             retire;
  logic [DEPTH-1:0] alc_oh;
  logic [DEPTH-1:0] ret_oh;
  logic [DEPTH-1:0] hit_rs1;
  logic [DEPTH-1:0] hit_rs2;
  logic [DEPTH-1:0] hit_rd;

  assign alc_idx = alc_ptr_reg[PTR_W-1:0];
  assign ret_idx = ret_ptr_reg[PTR_W-1:0];
  assign empty   = (alc_ptr_reg == ret_ptr_reg);
  assign full    = (alc_idx == ret_idx) && (alc_ptr_reg[PTR_W] != ret_ptr_reg[PTR_W]);

  // Flush wins over both requests. Acceptance looks only at registered
  // occupancy, so a full tracker refuses a dispatch even when a retire
  // happens in the same cycle.
  assign alloc  = bus.dis_ena & ~full  & ~bus.flush;
  assign retire = bus.ret_ena & ~empty & ~bus.flush;

  always_comb begin
    alc_oh          = '0;
    ret_oh          = '0;
    alc_oh[alc_idx] = 1'b1;
    ret_oh[ret_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alc_ptr_reg <= '0;
      ret_ptr_reg <= '0;
      count_reg   <= '0;
      ret_err_reg <= 1'b0;
    end else if (bus.flush) begin
      alc_ptr_reg <= '0;
      ret_ptr_reg <= '0;
      count_reg   <= '0;
    end else begin
      if (alloc)  alc_ptr_reg <= alc_ptr_reg + ONE;
      if (retire) ret_ptr_reg <= ret_ptr_reg + ONE;
      case ({alloc, retire})
        2'b10:   count_reg <= count_reg + ONE;
        2'b01:   count_reg <= count_reg - ONE;
        default: count_reg <= count_reg;
      endcase
      if (bus.ret_ena && empty) ret_err_reg <= 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          vld_reg[gi] <= 1'b0;
        else if (bus.flush)
          vld_reg[gi] <= 1'b0;
        else if (alloc && alc_oh[gi])
          vld_reg[gi] <= 1'b1;
        else if (retire && ret_oh[gi])
          vld_reg[gi] <= 1'b0;
      end

      always_ff @(posedge clk) begin
        if (alloc && alc_oh[gi]) begin
          rdwen_reg[gi] <= bus.dis_rdwen;
          rdidx_reg[gi] <= bus.dis_rdidx;
        end
      end

      // Only live, register-writing entries take part in hazard detection.
      assign hit_rs1[gi] = vld_reg[gi] & rdwen_reg[gi] & (rdidx_reg[gi] == bus.dis_rs1idx);
      assign hit_rs2[gi] = vld_reg[gi] & rdwen_reg[gi] & (rdidx_reg[gi] == bus.dis_rs2idx);
      assign hit_rd[gi]  = vld_reg[gi] & rdwen_reg[gi] & (rdidx_reg[gi] == bus.dis_rdidx);
    end
  endgenerate

  assign bus.match_rs1 = bus.dis_rs1en & (|hit_rs1);
  assign bus.match_rs2 = bus.dis_rs2en & (|hit_rs2);
  assign bus.match_rd  = bus.dis_rdwen & bus.dis_ena & (|hit_rd);

  // When the tracker is empty, the entry under ret_ptr may be stale.
  // Both retire outputs are therefore forced to zero in that case.
  assign bus.ret_rdidx = empty ? '0 : rdidx_reg[ret_idx];
  assign bus.ret_rdwen = ~empty & rdwen_reg[ret_idx];

  assign bus.dis_ready = ~full;
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.count     = count_reg;
  assign bus.ret_err   = ret_err_reg;

endmodule
